// File: rtl/cnn_pkg.sv
// Shared types and helpers for the convolution window streamer.
// Holds the default data width, the streamer state enum and output sizing.
package cnn_pkg;

  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_e;

  function automatic int out_dim(
    input int img,
    input int pad,
    input int k,
    input int stride
  );
    return (img + 2 * pad - k) / stride + 1;
  endfunction

endpackage

// File: rtl/window_counter.sv
// Nested kc/ocol/orow beat counter for the window streamer.
// kc runs fastest, then ocol, then orow; wraps to zero after the last beat.
module window_counter #(
  parameter int K   = 3,
  parameter int OUT = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     adv_i,
  output logic [$clog2(K+1)-1:0]   kc_o,
  output logic [$clog2(OUT+1)-1:0] ocol_o,
  output logic [$clog2(OUT+1)-1:0] orow_o,
  output logic                     col_first_o,
  output logic                     win_last_o,
  output logic                     frame_last_o
);

  localparam int KW = $clog2(K + 1);
  localparam int OW = $clog2(OUT + 1);
  localparam logic [KW-1:0] KL = KW'(K - 1);
  localparam logic [OW-1:0] OL = OW'(OUT - 1);

  logic [KW-1:0] kc_q, kc_d;
  logic [OW-1:0] ocol_q, ocol_d;
  logic [OW-1:0] orow_q, orow_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kc_q   <= '0;
      ocol_q <= '0;
      orow_q <= '0;
    end else begin
      kc_q   <= kc_d;
      ocol_q <= ocol_d;
      orow_q <= orow_d;
    end
  end

  always_comb begin
    kc_d   = kc_q;
    ocol_d = ocol_q;
    orow_d = orow_q;
    if (clr_i) begin
      kc_d   = '0;
      ocol_d = '0;
      orow_d = '0;
    end else if (adv_i) begin
      if (kc_q == KL) begin
        kc_d = '0;
        if (ocol_q == OL) begin
          ocol_d = '0;
          orow_d = (orow_q == OL) ? '0 : orow_q + OW'(1);
        end else begin
          ocol_d = ocol_q + OW'(1);
        end
      end else begin
        kc_d = kc_q + KW'(1);
      end
    end
  end

  assign kc_o         = kc_q;
  assign ocol_o       = ocol_q;
  assign orow_o       = orow_q;
  assign col_first_o  = (kc_q == '0);
  assign win_last_o   = (kc_q == KL);
  assign frame_last_o = (kc_q == KL) && (ocol_q == OL) && (orow_q == OL);

endmodule

// File: rtl/conv_window_streamer.sv
// Captures an image and KxK filter, then streams every padded, strided
// convolution window as K column beats over a valid/ready handshake.
module conv_window_streamer
  import cnn_pkg::*;
#(
  parameter int IMG    = 14,
  parameter int PAD    = 0,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int DW     = DW_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  send,
  input  logic [0:IMG*IMG*DW-1] img_in,
  input  logic [0:K*K*DW-1]     fil_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:K*DW-1]       win_col,
  output logic [0:K*DW-1]       fil_col,
  output logic                  col_first,
  output logic                  win_last,
  output logic                  frame_last,
  output logic                  busy,
  output logic                  pass
);

  localparam int OUT = out_dim(IMG, PAD, K, STRIDE);
  localparam int KW  = $clog2(K + 1);
  localparam int OW  = $clog2(OUT + 1);

  if (IMG + 2 * PAD < K) begin : g_bad_size
    $error("IMG+2*PAD must be at least K");
  end
  if (STRIDE < 1) begin : g_bad_stride
    $error("STRIDE must be at least 1");
  end
  if (PAD >= K) begin : g_bad_pad
    $error("PAD must be below K");
  end

  state_e                state_q, state_d;
  logic [0:IMG*IMG*DW-1] img_q;
  logic [0:K*K*DW-1]     fil_q;

  logic [KW-1:0] kc;
  logic [OW-1:0] ocol, orow;
  logic          cf_w, wl_w, fl_w;
  logic          start, fire;

  assign start = (state_q == IDLE) && send;
  assign fire  = out_valid && out_ready;

  window_counter #(
    .K  (K),
    .OUT(OUT)
  ) u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (start),
    .adv_i       (fire),
    .kc_o        (kc),
    .ocol_o      (ocol),
    .orow_o      (orow),
    .col_first_o (cf_w),
    .win_last_o  (wl_w),
    .frame_last_o(fl_w)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      img_q   <= '0;
      fil_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        img_q <= img_in;
        fil_q <= fil_in;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    busy      = 1'b0;
    pass      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (send) state_d = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (fire && fl_w) state_d = DONE;
      end
      DONE: begin
        pass    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign col_first  = busy && cf_w;
  assign win_last   = busy && wl_w;
  assign frame_last = busy && fl_w;

  // Row/column math is done in int so negative padded coordinates never wrap.
  int rr, cc;
  always_comb begin
    win_col = '0;
    fil_col = '0;
    rr      = 0;
    cc      = 0;
    if (out_valid) begin
      for (int i = 0; i < K; i++) begin
        rr = int'(orow) * STRIDE + i - PAD;
        cc = int'(ocol) * STRIDE + int'(kc) - PAD;
        if (rr >= 0 && rr < IMG && cc >= 0 && cc < IMG)
          win_col[i*DW +: DW] = img_q[(IMG*rr+cc)*DW +: DW];
        fil_col[i*DW +: DW] = fil_q[(K*i+int'(kc))*DW +: DW];
      end
    end
  end

endmodule
